// File: rtl/score_display_bcd.sv
// Scoreboard display engine: captures binary scores, converts them to BCD one channel
// at a time with a shift-add-3 sequencer, and drives registered active-low segment patterns.
module score_display_bcd #(
    parameter int SCORE_W  = 10,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*SCORE_W-1:0]    score,
    input  logic                           update,
    input  logic                           blank_en,
    output logic [CHANNELS*DIGITS*7-1:0]   seg,
    output logic [CHANNELS-1:0]            ovf,
    output logic                           busy,
    output logic                           done
);
    // state | meaning
    // IDLE  | waiting for update or a merged pending request
    // SHIFT | one double-dabble step per cycle, SCORE_W steps per channel
    // WRITE | convert current channel's BCD to segments, then next channel
    // DONE  | one-cycle completion pulse
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 0) begin
            n++;
            v = v / 10;
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b0111111;
        endcase
    endfunction

    // BCD accumulator wide enough for any SCORE_W value and for every displayed digit
    localparam int BIN_DIG = dec_digits(SCORE_W);
    localparam int NB      = (BIN_DIG > DIGITS) ? BIN_DIG : DIGITS;
    localparam int BCD_W   = NB * 4;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam longint unsigned LIMIT = pow10(DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [1:0]         state;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    ch_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic [SCORE_W-1:0] sh_score [CHANNELS];
    logic               sh_blank;
    logic [SCORE_W-1:0] bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [DIGITS-1:0]  blank_d;
    logic               lead;
    logic               ovf_now;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // A digit blanks only when it and every digit to its left are zero
    always_comb begin
        lead    = sh_blank;
        blank_d = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            lead       = lead && (bcd[d*4 +: 4] == 4'd0);
            blank_d[d] = lead && (d != 0);
        end
    end

    assign ch_nxt  = ch + CH_W'(1);
    assign ovf_now = (64'(sh_score[ch]) >= LIMIT);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            sh_blank <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            seg      <= '1;
            ovf      <= '0;
            for (int c = 0; c < CHANNELS; c++) sh_score[c] <= '0;
        end else begin
            if (state != IDLE && update) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (update || pending) begin
                        for (int c = 0; c < CHANNELS; c++)
                            sh_score[c] <= score[c*SCORE_W +: SCORE_W];
                        sh_blank <= blank_en;
                        ch       <= '0;
                        bin      <= score[0 +: SCORE_W];
                        bcd      <= '0;
                        cnt      <= '0;
                        pending  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= (bcd_adj << 1) | BCD_W'(bin[SCORE_W-1]);
                    bin <= bin << 1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SCORE_W - 1)) state <= WRITE;
                end
                WRITE: begin
                    ovf[ch] <= ovf_now;
                    for (int d = 0; d < DIGITS; d++) begin
                        if (ovf_now)
                            seg[(int'(ch)*DIGITS + d)*7 +: 7] <= SEG_DASH;
                        else if (blank_d[d])
                            seg[(int'(ch)*DIGITS + d)*7 +: 7] <= SEG_BLANK;
                        else
                            seg[(int'(ch)*DIGITS + d)*7 +: 7] <= seg_code(bcd[d*4 +: 4]);
                    end
                    if (ch == CH_W'(CHANNELS - 1)) begin
                        state <= DONE;
                    end else begin
                        ch    <= ch_nxt;
                        bin   <= sh_score[ch_nxt];
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_display_bcd.sv
// Bench for score_display_bcd: directed and random passes checked against a decimal
// arithmetic model of the display, on a default and a wider parametrised instance.
module tb_score_display_bcd;
    logic        clk = 1'b0;
    logic        reset_a, update_a, blank_a;
    logic [19:0] score_a;
    logic [41:0] seg_a;
    logic [1:0]  ovf_a;
    logic        busy_a, done_a;

    logic        reset_b, update_b, blank_b;
    logic [41:0] score_b;
    logic [83:0] seg_b;
    logic [2:0]  ovf_b;
    logic        busy_b, done_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    score_display_bcd dut_a (
        .clk(clk), .reset(reset_a), .score(score_a), .update(update_a), .blank_en(blank_a),
        .seg(seg_a), .ovf(ovf_a), .busy(busy_a), .done(done_a)
    );

    score_display_bcd #(.SCORE_W(14), .DIGITS(4), .CHANNELS(3)) dut_b (
        .clk(clk), .reset(reset_b), .score(score_b), .update(update_b), .blank_en(blank_b),
        .seg(seg_b), .ovf(ovf_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned pw10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Expected display for one channel: decimal digits by division, dashes on overflow
    function automatic logic [27:0] model_seg(input int unsigned v, input int nd, input bit bl);
        logic [27:0] r = '1;
        int unsigned p = 1;
        if (v >= pw10(nd)) begin
            for (int d = 0; d < nd; d++) r[d*7 +: 7] = 7'b0111111;
        end else begin
            for (int d = 0; d < nd; d++) begin
                if (bl && d >= 1 && v < p) r[d*7 +: 7] = 7'b1111111;
                else                       r[d*7 +: 7] = codes[(v / p) % 10];
                p = p * 10;
            end
        end
        return r;
    endfunction

    task automatic check_a(input string tag, input int unsigned s0, input int unsigned s1, input bit bl);
        logic [27:0] e;
        int unsigned s;
        for (int c = 0; c < 2; c++) begin
            s = (c == 0) ? s0 : s1;
            e = model_seg(s, 3, bl);
            chk($sformatf("%s_seg%0d", tag, c), seg_a[c*21 +: 21], e[20:0]);
            chk($sformatf("%s_ovf%0d", tag, c), ovf_a[c], (s >= 1000));
        end
    endtask

    task automatic accept_a(input int unsigned s0, input int unsigned s1, input bit bl);
        @(negedge clk);
        score_a  = {s1[9:0], s0[9:0]};
        blank_a  = bl;
        update_a = 1'b1;
        @(posedge clk);
        #1;
        update_a = 1'b0;
    endtask

    // Follows a pass from just after its accept edge until busy drops
    task automatic wait_pass_a(input int p1, input int p2, input int p3, input int mid_s0,
                               output int lat, output int busy_cnt, output int t0, output int t1);
        logic [20:0] prev0, prev1;
        prev0 = seg_a[20:0];
        prev1 = seg_a[41:21];
        lat = -1; t0 = -1; t1 = -1;
        busy_cnt = busy_a ? 1 : 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            update_a = (k == p1 || k == p2 || k == p3);
            if (k == p1 && mid_s0 >= 0) score_a[9:0] = mid_s0[9:0];
            if (busy_a) busy_cnt++;
            if (t0 < 0 && seg_a[20:0] !== prev0) t0 = k;
            if (t1 < 0 && seg_a[41:21] !== prev1) t1 = k;
            if (lat < 0 && done_a) lat = k;
            if (!busy_a) break;
        end
        update_a = 1'b0;
    endtask

    initial begin
        int lat, bc, t0, t1;
        int unsigned r0, r1;
        bit rb, saw_busy, saw_done;
        logic [27:0] e;

        reset_a = 1'b1; update_a = 1'b0; blank_a = 1'b0; score_a = '0;
        reset_b = 1'b1; update_b = 1'b0; blank_b = 1'b0; score_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Reset state, and score changes without update have no effect
        score_a = {10'd77, 10'd55};
        repeat (5) @(posedge clk);
        #1;
        chk("rst_seg", seg_a, {42{1'b1}});
        chk("rst_ovf", ovf_a, 2'b00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_seg_b", seg_b, {84{1'b1}});

        // Basic conversion with timing
        accept_a(123, 7, 1'b0);
        wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
        check_a("basic", 123, 7, 1'b0);
        chk("basic_lat", lat, 22);
        chk("basic_busy_cycles", bc, 23);
        chk("basic_t0", t0, 11);
        chk("basic_t1", t1, 22);

        // Leading-zero blanking
        accept_a(5, 40, 1'b1);
        wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
        check_a("blank", 5, 40, 1'b1);
        accept_a(0, 40, 1'b1);
        wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
        check_a("blank_zero", 0, 40, 1'b1);

        // Overflow boundary
        accept_a(1000, 999, 1'b0);
        wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
        check_a("ovf", 1000, 999, 1'b0);
        chk("ovf_vec", ovf_a, 2'b01);

        // Pending request with score changed mid-pass
        accept_a(200, 300, 1'b0);
        wait_pass_a(5, 0, 0, 456, lat, bc, t0, t1);
        check_a("pend1", 200, 300, 1'b0);
        chk("pend_idle_busy", busy_a, 1'b0);
        @(posedge clk);
        #1;
        chk("pend_restart_busy", busy_a, 1'b1);
        wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
        chk("pend2_lat", lat, 22);
        check_a("pend2", 456, 300, 1'b0);

        // Three requests during one pass merge into one extra pass
        accept_a(11, 22, 1'b1);
        wait_pass_a(3, 8, 15, -1, lat, bc, t0, t1);
        check_a("merge1", 11, 22, 1'b1);
        @(posedge clk);
        #1;
        chk("merge_restart_busy", busy_a, 1'b1);
        wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
        saw_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (busy_a) saw_busy = 1'b1;
        end
        chk("merge_no_third", saw_busy, 1'b0);

        // Randomized passes
        for (int i = 0; i < 8; i++) begin
            r0 = $urandom_range(0, 1023);
            r1 = $urandom_range(0, 1023);
            rb = 1'($urandom_range(0, 1));
            accept_a(r0, r1, rb);
            wait_pass_a(0, 0, 0, -1, lat, bc, t0, t1);
            check_a($sformatf("rnd%0d", i), r0, r1, rb);
            chk($sformatf("rnd%0d_lat", i), lat, 22);
        end

        // Reset in the middle of a pass, with a pending request queued
        accept_a(321, 654, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            update_a = (k == 2);
        end
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        chk("mrst_seg", seg_a, {42{1'b1}});
        chk("mrst_busy", busy_a, 1'b0);
        chk("mrst_ovf", ovf_a, 2'b00);
        saw_busy = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (busy_a) saw_busy = 1'b1;
            if (done_a) saw_done = 1'b1;
        end
        chk("mrst_no_done", saw_done, 1'b0);
        chk("mrst_no_pending", saw_busy, 1'b0);

        // Wider instance: 14-bit scores, 4 digits, 3 channels
        @(negedge clk);
        score_b  = {14'd10000, 14'd0, 14'd9999};
        blank_b  = 1'b1;
        update_b = 1'b1;
        @(posedge clk);
        #1;
        update_b = 1'b0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done_b) begin
                lat = k;
                break;
            end
        end
        chk("b_lat", lat, 45);
        @(posedge clk);
        #1;
        chk("b_busy_fall", busy_b, 1'b0);
        e = model_seg(9999, 4, 1'b1);
        chk("b_seg0", seg_b[0 +: 28], e);
        e = model_seg(0, 4, 1'b1);
        chk("b_seg1", seg_b[28 +: 28], e);
        e = model_seg(10000, 4, 1'b1);
        chk("b_seg2", seg_b[56 +: 28], e);
        chk("b_ovf", ovf_b, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
